// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: AHB transfer/response codes and the AHB-to-APB bridge state
// encoding shared by the bridge and its environment.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_t;

  // NONSEQ and SEQ request a transfer; IDLE and BUSY do not.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_to_apb_bridge.sv
// ahb_to_apb_bridge: AHB-Lite slave converting single AHB transfers into APB3
// transfers on one APB segment. All outputs are registered.
// Optional feature: define AHB_APB_PSLVERR_EN to map APB PSLVERR onto a
// two-cycle AHB ERROR response; without it PSLVERR is ignored and HRESP is 0.
module ahb_to_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  bridge_state_t state;
  logic          accept;

  // HSIZE is irrelevant (all APB accesses are 32-bit); only the in-segment
  // word address bits of HADDR reach PADDR.
  logic unused_inputs;
`ifdef AHB_APB_PSLVERR_EN
  assign unused_inputs = ^{HSIZE, HADDR[31:ADDR_WIDTH], HADDR[1:0]};
`else
  assign unused_inputs = ^{HSIZE, HADDR[31:ADDR_WIDTH], HADDR[1:0], PSLVERR};
`endif

  // A new transfer is only considered while the bridge is free to take one.
  assign accept = HSEL && HREADY && is_active_trans(HTRANS);

  // Bridge FSM with registered AHB response and APB outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      case (state)
`ifdef AHB_APB_PSLVERR_EN
        ST_IDLE, ST_ERR2: begin
`else
        ST_IDLE: begin
`endif
          if (accept) begin
            PADDR     <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
            PWRITE    <= HWRITE;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_OKAY;
            if (HWRITE) begin
              // write data only arrives in the following AHB data phase
              state <= ST_WDATA;
            end else begin
              PSEL  <= 1'b1;
              state <= ST_SETUP;
            end
          end else begin
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            state     <= ST_IDLE;
          end
        end

        ST_WDATA: begin
          PWDATA <= HWDATA;
          PSEL   <= 1'b1;
          state  <= ST_SETUP;
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (!PWRITE) begin
              HRDATA <= PRDATA;
            end
`ifdef AHB_APB_PSLVERR_EN
            if (PSLVERR) begin
              HRESP <= HRESP_ERROR;
              state <= ST_ERR1;
            end else begin
              HREADYOUT <= 1'b1;
              state     <= ST_IDLE;
            end
`else
            HREADYOUT <= 1'b1;
            state     <= ST_IDLE;
`endif
          end
        end

`ifdef AHB_APB_PSLVERR_EN
        ST_ERR1: begin
          HRESP     <= HRESP_ERROR;
          HREADYOUT <= 1'b1;
          state     <= ST_ERR2;
        end
`endif

        default: begin
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// tb_ahb_to_apb_bridge: directed bench for ahb_to_apb_bridge. Stimulus and
// expected outputs live in per-cycle tables: index k holds the inputs sampled
// at clock edge k and the outputs expected after edge k. Expected tables are
// filled from transfer-level timing rules (setup, access, wait states,
// completion, error response, reset abort).
module tb_ahb_to_apb_bridge;
  import ahb_apb_pkg::*;

  localparam int N = 70;

  logic        hclk = 1'b0;
  logic        hreset, hsel, hwrite, hready, hreadyout, hresp;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, hrdata, pwdata, prdata;
  logic [15:0] paddr;

  int errors = 0;
  int checks = 0;

  // stimulus tables
  logic        s_hreset [N];
  logic        s_hsel   [N];
  logic [1:0]  s_htrans [N];
  logic        s_hwrite [N];
  logic [2:0]  s_hsize  [N];
  logic [31:0] s_haddr  [N];
  logic [31:0] s_hwdata [N];
  logic        s_pready [N];
  logic [31:0] s_prdata [N];
  logic        s_pslverr[N];

  // expected output tables
  logic        e_hreadyout[N];
  logic        e_hresp    [N];
  logic [31:0] e_hrdata   [N];
  logic        e_psel     [N];
  logic        e_penable  [N];
  logic [15:0] e_paddr    [N];
  logic        e_pwrite   [N];
  logic [31:0] e_pwdata   [N];

  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb_to_apb_bridge #(.ADDR_WIDTH(16)) dut (
    .HCLK     (hclk),
    .HRESET   (hreset),
    .HSEL     (hsel),
    .HADDR    (haddr),
    .HTRANS   (htrans),
    .HWRITE   (hwrite),
    .HSIZE    (hsize),
    .HWDATA   (hwdata),
    .HREADY   (hready),
    .HREADYOUT(hreadyout),
    .HRESP    (hresp),
    .HRDATA   (hrdata),
    .PSEL     (psel),
    .PENABLE  (penable),
    .PADDR    (paddr),
    .PWRITE   (pwrite),
    .PWDATA   (pwdata),
    .PRDATA   (prdata),
    .PREADY   (pready),
    .PSLVERR  (pslverr)
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, want %h", name, k, act, req);
    end
  endtask

  // Quiet bus, idle APB slave with garbage data; expected = reset values.
  task automatic fill_defaults();
    for (int k = 0; k < N; k++) begin
      s_hreset[k]  = 1'b0;
      s_hsel[k]    = 1'b0;
      s_htrans[k]  = HTRANS_IDLE;
      s_hwrite[k]  = 1'b0;
      s_hsize[k]   = 3'(k);
      s_haddr[k]   = 32'h4000_0F00 + 32'(k);
      s_hwdata[k]  = 32'hF0F0_0000 + 32'(k);
      s_pready[k]  = 1'b1;
      s_prdata[k]  = 32'h0BAD_0000 + 32'(k);
      s_pslverr[k] = 1'b1;
    end
    reset_expect(0);
  endtask

  task automatic reset_expect(input int from);
    for (int k = from; k < N; k++) begin
      e_hreadyout[k] = 1'b1;
      e_hresp[k]     = 1'b0;
      e_hrdata[k]    = '0;
      e_psel[k]      = 1'b0;
      e_penable[k]   = 1'b0;
      e_paddr[k]     = '0;
      e_pwrite[k]    = 1'b0;
      e_pwdata[k]    = '0;
    end
  endtask

  // One AHB transfer accepted at edge a, address phase held from edge hold.
  // w = APB wait states, err = PSLVERR at completion. next = earliest edge a
  // following transfer can be accepted at.
  task automatic plan_xfer(input int a, input int hold, input bit wr, input logic [1:0] tr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int w, input bit err,
                           output int next);
    int s, l, d;
    for (int k = hold; k <= a; k++) begin
      s_hsel[k]   = 1'b1;
      s_htrans[k] = tr;
      s_hwrite[k] = wr;
      s_haddr[k]  = addr;
    end
    s = a + (wr ? 1 : 0);   // setup cycle
    l = s + 1 + w;          // last access cycle
    d = l + 1;              // completion cycle
    if (wr) s_hwdata[a+1] = wdata;
    for (int k = s + 2; k <= l; k++) s_pready[k] = 1'b0;
    s_pready[d]  = 1'b1;
    s_prdata[d]  = rdata;
    s_pslverr[d] = err;
    for (int k = a; k <= l; k++) e_hreadyout[k] = 1'b0;
    for (int k = s; k <= l; k++) e_psel[k] = 1'b1;
    for (int k = s + 1; k <= l; k++) e_penable[k] = 1'b1;
    for (int k = a; k < N; k++) begin
      e_paddr[k]  = {addr[15:2], 2'b00};
      e_pwrite[k] = wr;
    end
    if (wr) for (int k = a + 1; k < N; k++) e_pwdata[k] = wdata;
    if (!wr) for (int k = d; k < N; k++) e_hrdata[k] = rdata;
    next = d + 1;
`ifdef AHB_APB_PSLVERR_EN
    if (err) begin
      e_hresp[d]       = 1'b1;
      e_hreadyout[d]   = 1'b0;
      e_hresp[d+1]     = 1'b1;
      e_hreadyout[d+1] = 1'b1;
      next = d + 2;
    end
`endif
  endtask

  task automatic drive(input int k);
    hreset  = s_hreset[k];
    hsel    = s_hsel[k];
    htrans  = s_htrans[k];
    hwrite  = s_hwrite[k];
    hsize   = s_hsize[k];
    haddr   = s_haddr[k];
    hwdata  = s_hwdata[k];
    pready  = s_pready[k];
    prdata  = s_prdata[k];
    pslverr = s_pslverr[k];
  endtask

  initial begin : stimulus
    int nx;
    fill_defaults();
    for (int k = 0; k <= 2; k++) s_hreset[k] = 1'b1;
    // read, no wait states
    plan_xfer(4, 4, 1'b0, HTRANS_NONSEQ, 32'h4000_0104, '0, 32'hDEAD_BEEF, 0, 1'b0, nx);
    // BUSY, deselected NONSEQ write, IDLE: none may start a transfer
    s_hsel[7] = 1'b1; s_htrans[7] = HTRANS_BUSY;
    s_hsel[8] = 1'b0; s_htrans[8] = HTRANS_NONSEQ; s_hwrite[8] = 1'b1;
    s_hsel[9] = 1'b1; s_htrans[9] = HTRANS_IDLE;
    // write
    plan_xfer(10, 10, 1'b1, HTRANS_NONSEQ, 32'h4000_0008, 32'h1234_5678, '0, 0, 1'b0, nx);
    // read with 4 wait states
    plan_xfer(15, 15, 1'b0, HTRANS_NONSEQ, 32'h4000_0010, '0, 32'hCAFE_F00D, 4, 1'b0, nx);
    // read with slave error
    plan_xfer(23, 23, 1'b0, HTRANS_NONSEQ, 32'h4000_0020, '0, 32'h5555_AAAA, 0, 1'b1, nx);
    // back-to-back write then read, read address held through write wait states
    plan_xfer(29, 29, 1'b1, HTRANS_NONSEQ, 32'h4000_0030, 32'h0BEE_F001, '0, 1, 1'b0, nx);
    plan_xfer(nx, 30, 1'b0, HTRANS_SEQ, 32'h4000_0044, '0, 32'h7777_1111, 0, 1'b0, nx);
    // erroring write followed immediately by a read
    plan_xfer(39, 39, 1'b1, HTRANS_NONSEQ, 32'h4000_0050, 32'h1357_9BDF, '0, 0, 1'b1, nx);
    plan_xfer(nx, 40, 1'b0, HTRANS_NONSEQ, 32'h4000_0060, '0, 32'h2468_ACE0, 0, 1'b0, nx);
    // read aborted by reset during access
    plan_xfer(50, 50, 1'b0, HTRANS_NONSEQ, 32'h4000_0070, '0, 32'h9999_9999, 5, 1'b0, nx);
    s_hreset[53] = 1'b1;
    reset_expect(53);
    // read after reset
    plan_xfer(60, 60, 1'b0, HTRANS_NONSEQ, 32'h4000_00FC, '0, 32'h0F0F_0F0F, 0, 1'b0, nx);

    drive(0);
    for (int k = 1; k < N; k++) begin
      @(posedge hclk);
      #1;
      drive(k);
    end
  end

  initial begin : compare
    int   rd_low, wr_low, wait_low, psel_rises;
    logic psel_q;
    rd_low = 0; wr_low = 0; wait_low = 0; psel_rises = 0; psel_q = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge hclk);
      chk("hreadyout", k, 32'(hreadyout), 32'(e_hreadyout[k]));
      chk("hresp",     k, 32'(hresp),     32'(e_hresp[k]));
      chk("hrdata",    k, hrdata,         e_hrdata[k]);
      chk("psel",      k, 32'(psel),      32'(e_psel[k]));
      chk("penable",   k, 32'(penable),   32'(e_penable[k]));
      chk("paddr",     k, 32'(paddr),     32'(e_paddr[k]));
      chk("pwrite",    k, 32'(pwrite),    32'(e_pwrite[k]));
      chk("pwdata",    k, pwdata,         e_pwdata[k]);

      if (k >= 4 && k <= 6 && hreadyout === 1'b0) rd_low++;
      if (k >= 10 && k <= 13 && hreadyout === 1'b0) wr_low++;
      if (k >= 15 && k <= 21 && hreadyout === 1'b0) wait_low++;
      if (psel === 1'b1 && psel_q !== 1'b1) psel_rises++;
      psel_q = psel;

      case (k)
        4: begin
          chk("t1_paddr", k, 32'(paddr), 32'h0000_0104);
          chk("t1_setup_psel", k, 32'(psel), 32'd1);
          chk("t1_setup_penable", k, 32'(penable), 32'd0);
        end
        5:  chk("t1_access_penable", k, 32'(penable), 32'd1);
        6: begin
          chk("t1_hrdata", k, hrdata, 32'hDEAD_BEEF);
          chk("t1_done_psel", k, 32'(psel), 32'd0);
        end
        11: begin
          chk("t2_setup_pwdata", k, pwdata, 32'h1234_5678);
          chk("t2_pwrite", k, 32'(pwrite), 32'd1);
          chk("t2_paddr", k, 32'(paddr), 32'h0000_0008);
        end
        12: chk("t2_access_pwdata", k, pwdata, 32'h1234_5678);
        13: chk("t2_hrdata_kept", k, hrdata, 32'hDEAD_BEEF);
        21: chk("t3_hrdata", k, hrdata, 32'hCAFE_F00D);
`ifdef AHB_APB_PSLVERR_EN
        25: begin
          chk("t4_err1_hresp", k, 32'(hresp), 32'd1);
          chk("t4_err1_hreadyout", k, 32'(hreadyout), 32'd0);
        end
        26: begin
          chk("t4_err2_hresp", k, 32'(hresp), 32'd1);
          chk("t4_err2_hreadyout", k, 32'(hreadyout), 32'd1);
        end
`else
        25: begin
          chk("t4_hresp", k, 32'(hresp), 32'd0);
          chk("t4_hreadyout", k, 32'(hreadyout), 32'd1);
        end
`endif
        52: chk("t8_access_penable", k, 32'(penable), 32'd1);
        53: begin
          chk("t8_reset_psel", k, 32'(psel), 32'd0);
          chk("t8_reset_penable", k, 32'(penable), 32'd0);
          chk("t8_reset_hreadyout", k, 32'(hreadyout), 32'd1);
        end
        62: chk("t9_hrdata", k, hrdata, 32'h0F0F_0F0F);
        default: ;
      endcase
    end
    chk("read_wait_states", N, 32'(rd_low), 32'd2);
    chk("write_wait_states", N, 32'(wr_low), 32'd3);
    chk("pready_low_wait_states", N, 32'(wait_low), 32'd6);
    chk("apb_transfer_count", N, 32'(psel_rises), 32'd10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
